// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch unit: entry layouts and the default reset PC.
package fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Entry handed to decode: instruction word plus the context it was fetched with.
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        epoch;
  } fetch_entry_t;

  // Bookkeeping for a request that has been issued but not yet answered.
  typedef struct packed {
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        epoch;
  } inflight_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_fifo.sv
// Small synchronous FIFO with flush, used for both the in-flight and output queues.
module fetch_fifo #(
  parameter int  DEPTH = 2,
  parameter type T     = logic [31:0],
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  T              push_data,
  input  logic          pop,
  output T              head,
  output logic [CW-1:0] count
);

  T              mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          empty;
  logic          full;
  logic          do_push;
  logic          do_pop;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointer and occupancy tracking; flush empties the queue and wins over push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      if (do_push && !do_pop)      count_reg <= count_reg + 1'b1;
      else if (do_pop && !do_push) count_reg <= count_reg - 1'b1;
    end
  end

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr_reg] <= push_data;
  end

  assign head  = mem[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC generation with prediction, credit-limited
// memory requests, epoch-based squash of stale responses, and a decode queue.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] bp_pc,
  input  logic        bp_taken,
  input  logic [31:0] bp_target,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic [31:0] fetch_inst,
  output logic [31:0] fetch_pc,
  output logic        fetch_valid,
  input  logic        fetch_ready,
  output logic        fetch_epoch,
  output logic        pred_taken,
  output logic [31:0] pred_target
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]     pc_reg, pc_next;
  logic            epoch_reg;
  logic [CW-1:0]   drop_cnt_reg, drop_cnt_next;

  inflight_entry_t if_push_data, if_head;
  logic [CW-1:0]   if_count;
  fetch_entry_t    of_push_data, of_head, out_entry;
  logic [CW-1:0]   of_count;
  logic            of_push;

  logic            req_fire;
  logic            dequeue;
  logic            resp_drop;
  logic [CW:0]     occupancy;

  // Outstanding requests plus buffered entries, net of this cycle's dequeue, bound new requests.
  assign dequeue        = fetch_valid && fetch_ready;
  assign occupancy      = {1'b0, if_count} + {1'b0, of_count} - {{CW{1'b0}}, dequeue};
  assign imem_req_valid = rst_n && !redirect_valid && (occupancy < (CW + 1)'(DEPTH));
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign imem_req_addr  = word_align(pc_reg);
  assign bp_pc          = pc_reg;

  assign resp_drop    = (drop_cnt_reg != '0);
  assign of_push      = imem_resp_valid && !resp_drop && !redirect_valid;
  assign if_push_data = '{pc: pc_reg, pred_taken: bp_taken, pred_target: bp_target, epoch: epoch_reg};
  assign of_push_data = '{inst: imem_resp_data, pc: if_head.pc, pred_taken: if_head.pred_taken,
                          pred_target: if_head.pred_target, epoch: if_head.epoch};

  fetch_fifo #(.DEPTH(DEPTH), .T(inflight_entry_t)) u_inflight_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (1'b0),
    .push      (req_fire),
    .push_data (if_push_data),
    .pop       (imem_resp_valid),
    .head      (if_head),
    .count     (if_count)
  );

  fetch_fifo #(.DEPTH(DEPTH), .T(fetch_entry_t)) u_out_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (of_push),
    .push_data (of_push_data),
    .pop       (dequeue),
    .head      (of_head),
    .count     (of_count)
  );

  // Next PC: redirect wins; otherwise advance only when the request is accepted.
  always_comb begin
    pc_next = pc_reg;
    if (redirect_valid)  pc_next = redirect_pc;
    else if (req_fire)   pc_next = bp_taken ? bp_target : pc_reg + 32'd4;
  end

  // Stale-response budget: everything outstanding at a redirect must be thrown away.
  always_comb begin
    drop_cnt_next = drop_cnt_reg;
    if (redirect_valid)
      drop_cnt_next = imem_resp_valid ? if_count - 1'b1 : if_count;
    else if (imem_resp_valid && resp_drop)
      drop_cnt_next = drop_cnt_reg - 1'b1;
  end

  // Architectural fetch state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg       <= RESET_PC;
      epoch_reg    <= 1'b0;
      drop_cnt_reg <= '0;
    end else begin
      pc_reg       <= pc_next;
      drop_cnt_reg <= drop_cnt_next;
      if (redirect_valid) epoch_reg <= ~epoch_reg;
    end
  end

  // Head of the decode queue, forced to zero when nothing is buffered.
  always_comb begin
    out_entry = '0;
    if (of_count != '0) out_entry = of_head;
  end

  assign fetch_valid = (of_count != '0) && !redirect_valid;
  assign fetch_inst  = out_entry.inst;
  assign fetch_pc    = out_entry.pc;
  assign fetch_epoch = out_entry.epoch;
  assign pred_taken  = out_entry.pred_taken;
  assign pred_target = out_entry.pred_target;

  // Memory must never answer a request that was not issued.
  resp_has_request: assert property (@(posedge clk) disable iff (!rst_n)
    imem_resp_valid |-> (if_count != '0));

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory model with random latency, a program-flow
// reference model of what decode must see, and directed scenarios with literal results.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int          DEPTH = 2;
  localparam logic [31:0] NONE  = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] bp_pc;
  logic        bp_taken = 1'b0;
  logic [31:0] bp_target = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic [31:0] fetch_inst;
  logic [31:0] fetch_pc;
  logic        fetch_valid;
  logic        fetch_ready = 1'b0;
  logic        fetch_epoch;
  logic        pred_taken;
  logic [31:0] pred_target;

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bp_pc          (bp_pc),
    .bp_taken       (bp_taken),
    .bp_target      (bp_target),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .fetch_inst     (fetch_inst),
    .fetch_pc       (fetch_pc),
    .fetch_valid    (fetch_valid),
    .fetch_ready    (fetch_ready),
    .fetch_epoch    (fetch_epoch),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    bit          taken;
    logic [31:0] target;
    bit          epoch;
    int          gen;
    int          due;
  } req_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    bit          taken;
    logic [31:0] target;
    bit          epoch;
  } ent_t;

  req_t        pending[$];
  ent_t        outq[$];
  logic [31:0] model_pc = '0;
  bit          model_epoch = 1'b0;
  int          gen = 0;

  int          lat_min = 1, lat_max = 1;
  int          req_ready_pct = 100, fetch_ready_pct = 100, redirect_pct = 0, pred_mode = 0;
  bit          force_redir = 1'b0;
  logic [31:0] force_redir_pc = '0;

  logic [31:0] fire_hist[$], deq_hist[$], deq_ep_hist[$], deq_tk_hist[$], deq_tg_hist[$];
  logic [31:0] rv_hist[$], addr_hist[$];

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic void pred(input logic [31:0] pc, output bit t, output logic [31:0] tgt);
    t   = 1'b0;
    tgt = '0;
    case (pred_mode)
      1: begin t = (pc == 32'h8); tgt = 32'h100; end
      2: begin
        t   = (pc[5:2] == 4'd7) || (pc[5:2] == 4'd12);
        tgt = (pc ^ 32'h0000_0340) & 32'h0000_0FFC;
      end
      default: ;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic clear_hist();
    fire_hist.delete(); deq_hist.delete(); deq_ep_hist.delete();
    deq_tk_hist.delete(); deq_tg_hist.delete(); rv_hist.delete(); addr_hist.delete();
  endtask

  function automatic logic [31:0] nth_fire(input int n);
    int k = 0;
    foreach (fire_hist[i]) begin
      if (fire_hist[i] != NONE) begin
        if (k == n) return fire_hist[i];
        k++;
      end
    end
    return NONE;
  endfunction

  function automatic int nth_deq(input int n);
    int k = 0;
    foreach (deq_hist[i]) begin
      if (deq_hist[i] != NONE) begin
        if (k == n) return i;
        k++;
      end
    end
    return -1;
  endfunction

  // One clock cycle: called at posedge+1, drives, checks at posedge+2, returns at next posedge+1.
  task automatic cycle();
    bit          t, exp_fv, exp_rv, deq, fire, resp, obs_deq;
    logic [31:0] tg;
    int          occ;
    req_t        r;
    ent_t        e;
    redirect_valid  = force_redir || ($urandom_range(0, 99) < redirect_pct);
    redirect_pc     = force_redir ? force_redir_pc : (32'($urandom_range(0, 1023)) << 2);
    imem_req_ready  = ($urandom_range(0, 99) < req_ready_pct);
    fetch_ready     = ($urandom_range(0, 99) < fetch_ready_pct);
    pred(bp_pc, t, tg);
    bp_taken        = t;
    bp_target       = tg;
    resp            = (pending.size() > 0) && (pending[0].due <= cyc);
    imem_resp_valid = resp;
    imem_resp_data  = resp ? pending[0].data : $urandom;
    #1;
    exp_fv = (outq.size() > 0) && !redirect_valid;
    deq    = exp_fv && fetch_ready;
    occ    = int'(pending.size()) + int'(outq.size()) - (deq ? 1 : 0);
    exp_rv = !redirect_valid && (occ < DEPTH);
    chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    chk("bp_pc", bp_pc, model_pc);
    if (exp_rv) chk("req_addr", imem_req_addr, {model_pc[31:2], 2'b00});
    chk("fetch_valid", 32'(fetch_valid), 32'(exp_fv));
    if (outq.size() > 0) begin
      chk("fetch_pc", fetch_pc, outq[0].pc);
      chk("fetch_inst", fetch_inst, outq[0].inst);
      chk("fetch_epoch", 32'(fetch_epoch), 32'(outq[0].epoch));
      chk("pred_taken", 32'(pred_taken), 32'(outq[0].taken));
      chk("pred_target", pred_target, outq[0].target);
    end else begin
      chk("empty_fetch_pc", fetch_pc, 32'h0);
      chk("empty_fetch_inst", fetch_inst, 32'h0);
    end
    fire    = imem_req_valid && imem_req_ready;
    obs_deq = fetch_valid && fetch_ready;
    fire_hist.push_back(fire ? imem_req_addr : NONE);
    deq_hist.push_back(obs_deq ? fetch_pc : NONE);
    deq_ep_hist.push_back(32'(fetch_epoch));
    deq_tk_hist.push_back(32'(pred_taken));
    deq_tg_hist.push_back(pred_target);
    rv_hist.push_back(32'(imem_req_valid));
    addr_hist.push_back(imem_req_addr);
    if (obs_deq)
      $display("[TB] cyc %0d deq pc=%h inst=%h ep=%0d taken=%0d", cyc, fetch_pc, fetch_inst,
               fetch_epoch, pred_taken);
    // Reference model update for the coming edge.
    if (deq) void'(outq.pop_front());
    if (resp) begin
      r = pending.pop_front();
      if (!redirect_valid && r.gen == gen) begin
        e = '{inst: memf({r.pc[31:2], 2'b00}), pc: r.pc, taken: r.taken, target: r.target,
              epoch: r.epoch};
        outq.push_back(e);
      end
    end
    if (fire) begin
      pred(model_pc, t, tg);
      pending.push_back('{pc: model_pc, data: memf(imem_req_addr), taken: t, target: tg,
                          epoch: model_epoch, gen: gen,
                          due: cyc + int'($urandom_range(lat_min, lat_max))});
      model_pc = t ? tg : model_pc + 32'd4;
    end
    if (redirect_valid) begin
      outq.delete();
      gen++;
      model_epoch = ~model_epoch;
      model_pc    = redirect_pc;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Called at posedge+1; returns at posedge+1 with reset released.
  task automatic do_reset();
    rst_n           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    fetch_ready     = 1'b1;
    bp_taken        = 1'b0;
    bp_target       = '0;
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
    chk("rst_fetch_valid", 32'(fetch_valid), 32'h0);
    chk("rst_fetch_pc", fetch_pc, 32'h0);
    chk("rst_fetch_inst", fetch_inst, 32'h0);
    chk("rst_bp_pc", bp_pc, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    pending.delete();
    outq.delete();
    model_pc    = 32'h0;
    model_epoch = 1'b0;
    gen++;
  endtask

  task automatic set_knobs(input int lmin, input int lmax, input int rr, input int fr,
                           input int rd, input int pm);
    lat_min = lmin; lat_max = lmax; req_ready_pct = rr; fetch_ready_pct = fr;
    redirect_pct = rd; pred_mode = pm; force_redir = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    int d;
    int nfires;
    @(posedge clk);
    #1;

    // Back-to-back fetch from reset with single-cycle memory.
    set_knobs(1, 1, 100, 100, 0, 0);
    do_reset(); clear_hist();
    repeat (6) cycle();
    chk("t1_req0", fire_hist[0], 32'h0);
    chk("t1_req1", fire_hist[1], 32'h4);
    chk("t1_req2", fire_hist[2], 32'h8);
    chk("t1_nodeq0", deq_hist[0], NONE);
    chk("t1_nodeq1", deq_hist[1], NONE);
    chk("t1_deq2", deq_hist[2], 32'h0);
    chk("t1_deq3", deq_hist[3], 32'h4);
    chk("t1_deq4", deq_hist[4], 32'h8);

    // Taken prediction at 0x8.
    set_knobs(1, 1, 100, 100, 0, 1);
    do_reset(); clear_hist();
    repeat (8) cycle();
    chk("t2_req3", fire_hist[3], 32'h100);
    chk("t2_deq_pc", deq_hist[4], 32'h8);
    chk("t2_deq_taken", deq_tk_hist[4], 32'h1);
    chk("t2_deq_target", deq_tg_hist[4], 32'h100);
    chk("t2_deq_next", deq_hist[5], 32'h100);

    // Decode stall: buffer fills to the credit limit, then drains in order.
    set_knobs(1, 1, 100, 0, 0, 0);
    do_reset(); clear_hist();
    repeat (10) cycle();
    nfires = 0;
    foreach (fire_hist[i]) if (fire_hist[i] != NONE) nfires++;
    chk("t3_fires_during_stall", 32'(nfires), 32'd2);
    chk("t3_req_valid_stalled", rv_hist[9], 32'h0);
    fetch_ready_pct = 100;
    repeat (3) cycle();
    chk("t3_release0", deq_hist[10], 32'h0);
    chk("t3_release1", deq_hist[11], 32'h4);

    // Redirect with two requests in flight.
    set_knobs(3, 3, 100, 100, 0, 0);
    force_redir_pc = 32'h200;
    do_reset(); clear_hist();
    for (int i = 0; i < 14; i++) begin
      force_redir = (i == 2);
      cycle();
    end
    force_redir = 1'b0;
    d = nth_deq(0);
    chk("t4_first_pc", (d >= 0) ? deq_hist[d] : NONE, 32'h200);
    chk("t4_first_epoch", (d >= 0) ? deq_ep_hist[d] : NONE, 32'h1);

    // Two consecutive redirects with stale requests outstanding.
    set_knobs(3, 3, 100, 100, 0, 0);
    do_reset(); clear_hist();
    for (int i = 0; i < 14; i++) begin
      force_redir    = (i == 2) || (i == 3);
      force_redir_pc = (i == 2) ? 32'h300 : 32'h400;
      cycle();
    end
    force_redir = 1'b0;
    d = nth_deq(0);
    chk("t5_first_pc", (d >= 0) ? deq_hist[d] : NONE, 32'h400);
    chk("t5_first_epoch", (d >= 0) ? deq_ep_hist[d] : NONE, 32'h0);

    // Memory back-pressure: request address holds, sequence unbroken.
    set_knobs(1, 1, 100, 100, 0, 0);
    do_reset(); clear_hist();
    for (int i = 0; i < 8; i++) begin
      req_ready_pct = (i >= 1 && i <= 3) ? 0 : 100;
      cycle();
    end
    for (int i = 1; i <= 3; i++) begin
      chk("t6_hold_valid", rv_hist[i], 32'h1);
      chk("t6_hold_addr", addr_hist[i], 32'h4);
    end
    chk("t6_seq0", nth_fire(0), 32'h0);
    chk("t6_seq1", nth_fire(1), 32'h4);
    chk("t6_seq2", nth_fire(2), 32'h8);

    // PC wraps modulo 2^32.
    set_knobs(1, 1, 100, 100, 0, 0);
    force_redir_pc = 32'hFFFF_FFFC;
    do_reset(); clear_hist();
    for (int i = 0; i < 6; i++) begin
      force_redir = (i == 0);
      cycle();
    end
    force_redir = 1'b0;
    chk("t7_req_top", nth_fire(0), 32'hFFFF_FFFC);
    chk("t7_req_wrap", nth_fire(1), 32'h0);
    d = nth_deq(0);
    chk("t7_deq_top", (d >= 0) ? deq_hist[d] : NONE, 32'hFFFF_FFFC);

    // Randomized traffic against the reference model.
    set_knobs(1, 4, 70, 70, 3, 2);
    do_reset(); clear_hist();
    repeat (3000) cycle();

    // Reset in the middle of traffic, then restart from the reset PC.
    do_reset(); clear_hist();
    set_knobs(1, 1, 100, 100, 0, 0);
    repeat (4) cycle();
    chk("t8_first_req_after_reset", fire_hist[0], 32'h0);
    chk("t8_first_deq_after_reset", deq_hist[2], 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter DEPTH, 2, combined in-flight + output-buffer capacity (credit limit).
REQ-003 clk  input  1  clock; all state updates on posedge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 redirect_valid  input  1  backend redirect request this cycle.
REQ-006 redirect_pc  input  32  new fetch PC on redirect.
REQ-007 bp_pc  output  32  current PC presented to predictor.
REQ-008 bp_taken  input  1  combinational prediction for bp_pc.
REQ-009 bp_target  input  32  predicted target for bp_pc.
REQ-010 imem_req_valid  output  1  instruction memory request.
REQ-011 imem_req_ready  input  1  memory accepts request.
REQ-012 imem_req_addr  output  32  word-aligned request address.
REQ-013 imem_resp_valid  input  1  response; in order, always accepted.
REQ-014 imem_resp_data  input  32  instruction word.
REQ-015 fetch_inst  output  32  instruction to decode.
REQ-016 fetch_pc  output  32  PC of fetch_inst.
REQ-017 fetch_valid  output  1  head entry valid.
REQ-018 fetch_ready  input  1  decode accepts head entry.
REQ-019 fetch_epoch  output  1  epoch tag of head entry.
REQ-020 pred_taken  output  1  prediction captured for fetch_pc.
REQ-021 pred_target  output  32  predicted target captured for fetch_pc.

Function
REQ-022 Request fire = imem_req_valid && imem_req_ready; decode dequeue = fetch_valid && fetch_ready.
REQ-023 imem_req_valid = !redirect_valid && (inflight_cnt + out_cnt - dequeue) < DEPTH.
REQ-024 imem_req_addr = {pc[31:2],2'b00}; bp_pc = pc.
REQ-025 On request fire: push {pc, bp_taken, bp_target, epoch} to in-flight FIFO (DEPTH entries); pc <= bp_taken ? bp_target : pc+4 (mod 2^32).
REQ-026 While imem_req_valid && !imem_req_ready, pc and imem_req_addr SHALL hold stable.
REQ-027 On imem_resp_valid: pop in-flight FIFO; if drop_cnt > 0, discard response and decrement drop_cnt; else push {data, pc, pred, epoch} to output FIFO (DEPTH entries).
REQ-028 Credit rule (REQ-023) guarantees no output FIFO overflow; response arriving with empty in-flight FIFO is a protocol error (assertion).
REQ-029 fetch_valid = out FIFO non-empty && !redirect_valid; fetch_* outputs = head entry fields, zero when empty.
REQ-030 On redirect_valid: pc <= redirect_pc; epoch toggles; output FIFO flushed; drop_cnt <= inflight_cnt minus 1 if response arrives same cycle, else inflight_cnt.
REQ-031 Redirect takes priority over request fire, response enqueue and dequeue in the same cycle.
REQ-032 Simultaneous response enqueue and dequeue SHALL both occur; out_cnt unchanged.
REQ-033 FIFO pointers wrap modulo DEPTH; counters width clog2(DEPTH+1).
REQ-034 Minimum latency: request fire cycle N, response cycle N+1, fetch_valid cycle N+2.

Reset
REQ-035 On rst_n low: pc=RESET_PC, epoch=0, drop_cnt=0, both FIFOs empty; imem_req_valid=0 while in reset, fetch_valid=0, fetch_* data outputs=0.
REQ-036 Reset mid-operation discards all in-flight and buffered entries; first request after release uses RESET_PC.

Structure
REQ-037 fetch_entry_t (inst, pc, pred_taken, pred_target, epoch) and RESET_PC default SHALL reside in the shared defines package.
REQ-038 One sub-module fetch_fifo (parameterized depth/type, push/pop/flush, count) SHALL implement both FIFOs.

Verification
REQ-039 Reset release, 1-cycle memory, fetch_ready=1, no taken predictions -> requests 0x0,0x4,0x8 back-to-back; fetch_pc 0x0,0x4,0x8 on consecutive cycles starting cycle 2.
REQ-040 bp_taken=1, bp_target=0x100 at pc 0x8 -> next request 0x100; entry for 0x8 carries pred_taken=1, pred_target=0x100.
REQ-041 fetch_ready=0 for 10 cycles -> exactly 2 entries buffered, imem_req_valid=0, order preserved on release.
REQ-042 Redirect to 0x200 with 2 requests in flight -> both responses discarded, fetch_epoch toggled, first fetch_pc=0x200.
REQ-043 Two redirects (0x300, then 0x400) one cycle apart with in-flight requests -> all stale responses dropped, first fetch_pc=0x400.
REQ-044 imem_req_ready low 3 cycles -> imem_req_addr stable, no duplicate or skipped PC.
